// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate formats into a registered
// output stage backed by one skid entry. Define IMM_GEN_PERF_EN to add perf_count.
package imm_gen_pkg;
    typedef enum logic [2:0] {
        IMM_I_TYPE = 3'd0,
        IMM_STORE  = 3'd1,
        IMM_BRANCH = 3'd2,
        IMM_JAL    = 3'd3,
        IMM_U_TYPE = 3'd4,
        IMM_CSR    = 3'd5,
        IMM_SHAMT  = 3'd6
    } imm_e;
endpackage

module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  imm_e             imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
`ifdef IMM_GEN_PERF_EN
    ,
    output logic [31:0]      perf_count
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // out_* fields hold steady while out_valid=1 and out_ready=0.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state;

    logic out_full;
    logic skid_full;
    logic accept;
    logic drain;

    logic [XLEN-1:0]  imm_c;
    logic             ill_c;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;

    assign out_full  = (state != ST_EMPTY);
    assign skid_full = (state == ST_TWO);
    assign out_valid = out_full;
    assign accept    = in_valid && in_ready;
    assign drain     = out_full && out_ready;

    always_comb begin
        imm_c = '0;
        ill_c = 1'b0;
        case (imm_sel)
            IMM_I_TYPE: imm_c = XLEN'($signed(inst[31:20]));
            IMM_STORE:  imm_c = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_BRANCH: imm_c = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_JAL:    imm_c = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            IMM_U_TYPE: imm_c = XLEN'($signed({inst[31:12], 12'b0}));
            IMM_CSR:    imm_c = XLEN'(inst[19:15]);
            IMM_SHAMT:  imm_c = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            default:    ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            imm_data <= '0;
            out_tag  <= '0;
            illegal  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_ill <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        imm_data <= imm_c;
                        out_tag  <= in_tag;
                        illegal  <= ill_c;
                        state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_imm <= imm_c;
                        skid_tag <= in_tag;
                        skid_ill <= ill_c;
                        in_ready <= 1'b0;
                        state    <= ST_TWO;
                    end else if (accept && drain) begin
                        imm_data <= imm_c;
                        out_tag  <= in_tag;
                        illegal  <= ill_c;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is already low here, so only the drain side can move.
                    if (drain) begin
                        imm_data <= skid_imm;
                        out_tag  <= skid_tag;
                        illegal  <= skid_ill;
                        in_ready <= 1'b1;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef IMM_GEN_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_count <= '0;
        end else if (accept) begin
            perf_count <= perf_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input
// stream; an arithmetic reference model fills per-instance expected queues.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    imm_e        imm_sel = IMM_I_TYPE;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        ir32, ov32, il32, ir64, ov64, il64;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [3:0]  t32, t64;
`ifdef IMM_GEN_PERF_EN
    logic [31:0] perf32, perf64;
    logic [31:0] perf_exp = '0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit rand_mode = 1'b0;

    logic [68:0] exp32_q[$];
    logic [68:0] exp64_q[$];
    logic [68:0] log32[$];
    logic [68:0] log64[$];
    int          logc32[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .inst(inst),
        .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
        .imm_data(d32), .out_tag(t32), .illegal(il32)
`ifdef IMM_GEN_PERF_EN
        , .perf_count(perf32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .inst(inst),
        .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
        .imm_data(d64), .out_tag(t64), .illegal(il64)
`ifdef IMM_GEN_PERF_EN
        , .perf_count(perf64)
`endif
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: assemble the field value, then apply two's-complement sign by arithmetic.
    function automatic logic [68:0] make_exp(int xlen);
        longint     v;
        int         nb;
        bit         ill;
        logic [2:0] s;
        logic [63:0] r;
        v = 0; nb = 0; ill = 1'b0; s = imm_sel;
        case (s)
            3'd0: begin v = longint'(inst[31:20]); nb = 12; end
            3'd1: begin v = longint'({inst[31:25], inst[11:7]}); nb = 12; end
            3'd2: begin
                v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                  + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                nb = 13;
            end
            3'd3: begin
                v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
                  + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                nb = 21;
            end
            3'd4: begin v = longint'(inst[31:12]) * 4096; nb = 32; end
            3'd5: v = longint'(inst[19:15]);
            3'd6: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: ill = 1'b1;
        endcase
        if (nb > 0 && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
        r = 64'(v);
        if (xlen == 32) r[63:32] = '0;
        return {ill, in_tag, r};
    endfunction

    // Monitor: at each negedge, compare any presented output with the queue head,
    // pop on a transfer, then enqueue the expected result of any input transfer.
    always @(negedge clk) begin
        logic [68:0] e;
        if (ov32) begin
            if (exp32_q.size() == 0) check("spurious32", 64'(ov32), 64'd0);
            else begin
                e = exp32_q[0];
                check("imm32", 64'(d32), e[63:0]);
                check("tag32", 64'(t32), 64'(e[67:64]));
                check("ill32", 64'(il32), 64'(e[68]));
                if (out_ready && rst_n) begin
                    void'(exp32_q.pop_front());
                    log32.push_back({il32, t32, 32'd0, d32});
                    logc32.push_back(cyc);
                end
            end
        end
        if (ov64) begin
            if (exp64_q.size() == 0) check("spurious64", 64'(ov64), 64'd0);
            else begin
                e = exp64_q[0];
                check("imm64", d64, e[63:0]);
                check("tag64", 64'(t64), 64'(e[67:64]));
                check("ill64", 64'(il64), 64'(e[68]));
                if (out_ready && rst_n) begin
                    void'(exp64_q.pop_front());
                    log64.push_back({il64, t64, d64});
                end
            end
        end
`ifdef IMM_GEN_PERF_EN
        check("perf64", 64'(perf64), 64'(perf_exp));
        check("perf32", 64'(perf32), 64'(perf_exp));
`endif
        if (!rst_n) begin
            exp32_q.delete();
            exp64_q.delete();
`ifdef IMM_GEN_PERF_EN
            perf_exp = '0;
`endif
        end else begin
            if (in_valid && ir32) exp32_q.push_back(make_exp(32));
            if (in_valid && ir64) begin
                exp64_q.push_back(make_exp(64));
`ifdef IMM_GEN_PERF_EN
                perf_exp = perf_exp + 32'd1;
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(logic [31:0] i, logic [2:0] s, logic [3:0] t);
        int n;
        in_valid = 1'b1; inst = i; imm_sel = imm_e'(s); in_tag = t;
        n = 0;
        @(negedge clk);
        while (!(ir32 && ir64)) begin
            n++;
            if (n > 100) begin
                check("send_timeout", 64'(ir64), 64'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_logs(int n);
        int k;
        k = 0;
        while (log32.size() < n || log64.size() < n) begin
            k++;
            if (k > 200) begin
                check("drain_timeout", 64'(log64.size()), 64'(n));
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        log32.delete(); log64.delete(); logc32.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ov32", 64'(ov32), 64'd0);
        check("rst_ir32", 64'(ir32), 64'd1);
        check("rst_imm32", 64'(d32), 64'd0);
        check("rst_tag32", 64'(t32), 64'd0);
        check("rst_ill32", 64'(il32), 64'd0);
        check("rst_ov64", 64'(ov64), 64'd0);
        check("rst_ir64", 64'(ir64), 64'd1);
        check("rst_imm64", d64, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // I-type, one cycle latency from empty
        send(32'hFFF00093, 3'd0, 4'd1);
        @(negedge clk);
        check("lat_ov32", 64'(ov32), 64'd1);
        check("i_imm32", 64'(d32), 64'hFFFF_FFFF);
        check("i_ill32", 64'(il32), 64'd0);
        check("i_imm64", d64, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        clear_logs();

        // B then J back to back
        send(32'hFE000EE3, 3'd2, 4'd2);
        send(32'h0080006F, 3'd3, 4'd3);
        wait_logs(2);
        if (log32.size() >= 2) begin
            check("b_imm32", 64'(log32[0][31:0]), 64'hFFFF_FFFC);
            check("b_tag32", 64'(log32[0][67:64]), 64'd2);
            check("j_imm32", 64'(log32[1][31:0]), 64'h8);
            check("j_tag32", 64'(log32[1][67:64]), 64'd3);
            check("bj_consec", 64'(logc32[1] - logc32[0]), 64'd1);
        end
        clear_logs();

        // U and SHAMT at both widths
        send(32'h80000037, 3'd4, 4'd4);
        send(32'h03F09093, 3'd6, 4'd5);
        wait_logs(2);
        if (log64.size() >= 2 && log32.size() >= 2) begin
            check("u_imm64", log64[0][63:0], 64'hFFFF_FFFF_8000_0000);
            check("sh_imm64", log64[1][63:0], 64'h3F);
            check("u_imm32", 64'(log32[0][31:0]), 64'h8000_0000);
            check("sh_imm32", 64'(log32[1][31:0]), 64'h1F);
        end
        clear_logs();

        // undefined select
        send(32'hFFFF_FFFF, 3'd7, 4'd6);
        wait_logs(1);
        if (log64.size() >= 1) begin
            check("undef_imm64", log64[0][63:0], 64'd0);
            check("undef_ill64", 64'(log64[0][68]), 64'd1);
        end
        clear_logs();

        // backpressure: tags 1,2 absorbed, tag 3 held
        out_ready = 1'b0;
        fork
            begin
                send(32'h00100093, 3'd0, 4'd1);
                send(32'h00200093, 3'd0, 4'd2);
                send(32'h00300093, 3'd0, 4'd3);
            end
        join_none
        repeat (6) @(negedge clk);
        check("bp_ir32", 64'(ir32), 64'd0);
        check("bp_ir64", 64'(ir64), 64'd0);
        check("bp_ov64", 64'(ov64), 64'd1);
        check("bp_tag64", 64'(t64), 64'd1);
        check("bp_depth", 64'(exp64_q.size()), 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_logs(3);
        if (log64.size() >= 3) begin
            check("bp_ord0", 64'(log64[0][67:64]), 64'd1);
            check("bp_ord1", 64'(log64[1][67:64]), 64'd2);
            check("bp_ord2", 64'(log64[2][67:64]), 64'd3);
        end
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", 64'(log64.size()), 64'd3);
        clear_logs();

        // reset with both entries full
        out_ready = 1'b0;
        send(32'h00500093, 3'd0, 4'd7);
        send(32'h00600093, 3'd0, 4'd8);
        @(negedge clk);
        check("full_ir64", 64'(ir64), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_ov32", 64'(ov32), 64'd0);
        check("mrst_ir32", 64'(ir32), 64'd1);
        check("mrst_ov64", 64'(ov64), 64'd0);
        check("mrst_ir64", 64'(ir64), 64'd1);
`ifdef IMM_GEN_PERF_EN
        check("mrst_perf64", 64'(perf64), 64'd0);
`endif
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mrst_nolog", 64'(log64.size() + log32.size()), 64'd0);

        // randomized traffic with random backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send($urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_mode = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && (exp32_q.size() + exp64_q.size()) != 0; k++) @(negedge clk);
        check("final_empty", 64'(exp32_q.size() + exp64_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
